// File: rtl/data_mem_if.sv
// Data-memory port bundle between the CPU (master) and the memory
// responder (slave).
//   mem_read / mem_write : level requests, held until mem_ready
//   mem_addr             : 64-bit byte address (8-byte aligned)
//   write_data           : store data
//   data_out             : read data, held until the next read response
//   mem_ready            : one-cycle completion pulse
//   mem_err              : request rejected, valid with mem_ready
//   busy                 : request in flight
interface data_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] write_data;
    logic [63:0] data_out;
    logic        mem_ready;
    logic        mem_err;
    logic        busy;

    modport master (
        output mem_read, mem_write, mem_addr, write_data,
        input  data_out, mem_ready, mem_err, busy
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, write_data,
        output data_out, mem_ready, mem_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder. A request seen in IDLE is latched,
// held for LATENCY cycles (WAIT), then completed with a one-cycle
// mem_ready pulse (RESP). Illegal requests (read+write together,
// misaligned, or word index beyond DEPTH) complete with mem_err and
// never touch the array.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : data_mem_if.slave (requests in, data/ready/err/busy out)
// Parameters:
//   DEPTH   : number of 64-bit words (word index = mem_addr[63:3])
//   LATENCY : acceptance-to-mem_ready cycles, 1..15
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic      clock,
    input  logic      reset,
    data_mem_if.slave bus
);
    localparam int          IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [60:0] DEPTH_WORDS = 61'(DEPTH);
    localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             is_read_q, is_read_d;
    logic             is_write_q, is_write_d;
    logic             err_q, err_d;
    logic [63:0]      data_out_q, data_out_d;
    logic             mem_ready_q, mem_ready_d;
    logic             mem_err_q, mem_err_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;

    logic [63:0]      mem [DEPTH];
    logic             req_err;
    logic             mem_we;

    // The full 61-bit word index is compared so high address bits can
    // never alias onto a valid word.
    assign req_err = (bus.mem_read & bus.mem_write)
                   | (|bus.mem_addr[2:0])
                   | (bus.mem_addr[63:3] >= DEPTH_WORDS);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;
        is_write_d  = is_write_q;
        err_d       = err_q;
        data_out_d  = data_out_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mem_ready_d = 1'b0;
        mem_err_d   = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mem_read | bus.mem_write) begin
                    idx_d      = bus.mem_addr[IDX_W+2:3];
                    wdata_d    = bus.write_data;
                    is_read_d  = bus.mem_read;
                    is_write_d = bus.mem_write;
                    err_d      = req_err;
                    cnt_d      = CNT_INIT;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access happens on the WAIT->RESP edge.
                    state_d     = RESP;
                    mem_ready_d = 1'b1;
                    mem_err_d   = err_q;
                    mem_we      = is_write_q & ~err_q;
                    if (is_read_q) begin
                        data_out_d = err_q ? 64'd0 : mem[idx_q];
                    end
                end
            end
            RESP: begin
                // Always one IDLE cycle between accesses.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            is_read_q   <= 1'b0;
            is_write_q  <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= 64'd0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            is_write_q  <= is_write_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            busy_q      <= busy_d;
        end
    end

    // Latched address/data are only meaningful while state_q != IDLE.
    always_ff @(posedge clock) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // Async reset forces IDLE, so an access aborted by reset never writes.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.busy      = busy_q;
endmodule
